// File: rtl/lcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : lcd_seq
// Purpose  : Walks the 8-slot LCD command bank and replays each valid entry
//            as timed HD44780 8-bit write cycles (optional address + data).
// Revision : 1.0 - initial release
// ============================================================================
module lcd_seq #(
    parameter int T_SETUP = 3,
    parameter int T_PULSE = 12,
    parameter int T_HOLD  = 2,
    parameter int T_SHORT = 2500,
    parameter int T_LONG  = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] Address_in,
    input  logic [7:0] Control_in,
    input  logic [7:0] Data_in,
    output logic [2:0] sel_out,
    output logic [7:0] status,
    output logic       busy,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_db
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_FETCH  = 3'd1;
    localparam logic [2:0] c_DECODE = 3'd2;
    localparam logic [2:0] c_SETUP  = 3'd3;
    localparam logic [2:0] c_PULSE  = 3'd4;
    localparam logic [2:0] c_HOLD   = 3'd5;
    localparam logic [2:0] c_WAIT   = 3'd6;
    localparam logic [2:0] c_NEXT   = 3'd7;

    // Timed states load (duration - 1) and leave when the counter reaches 0.
    localparam logic [16:0] c_SETUP_LD = 17'(T_SETUP - 1);
    localparam logic [16:0] c_PULSE_LD = 17'(T_PULSE - 1);
    localparam logic [16:0] c_HOLD_LD  = 17'(T_HOLD - 1);
    localparam logic [16:0] c_SHORT_LD = 17'(T_SHORT - 1);
    localparam logic [16:0] c_LONG_LD  = 17'(T_LONG - 1);
    localparam logic [16:0] c_FETCH_LD = 17'd1;

    logic [2:0]  r_state;
    logic [16:0] r_cnt;
    logic [2:0]  r_slot;
    logic        r_busy;
    logic        r_done;
    logic [7:0]  r_addr_q;
    logic [7:0]  r_ctrl_q;
    logic [7:0]  r_data_q;
    logic        r_addr_phase;
    logic [16:0] r_wait_ld;
    logic        r_lcd_rs;
    logic        r_lcd_e;
    logic [7:0]  r_lcd_db;

    logic        w_cnt_zero;
    logic [16:0] w_data_wait;
    logic        w_unused;

    assign w_cnt_zero  = (r_cnt == 17'd0);
    assign w_data_wait = r_ctrl_q[2] ? c_LONG_LD : c_SHORT_LD;
    assign w_unused    = ^{r_ctrl_q[7:4], r_addr_q[7]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_cnt        <= 17'd0;
            r_slot       <= 3'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_addr_q     <= 8'h00;
            r_ctrl_q     <= 8'h00;
            r_data_q     <= 8'h00;
            r_addr_phase <= 1'b0;
            r_wait_ld    <= 17'd0;
            r_lcd_rs     <= 1'b0;
            r_lcd_e      <= 1'b0;
            r_lcd_db     <= 8'h00;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_done  <= 1'b0;
                        r_slot  <= 3'd0;
                        r_busy  <= 1'b1;
                        r_cnt   <= c_FETCH_LD;
                        r_state <= c_FETCH;
                    end
                end
                c_FETCH: begin
                    // Bank output lags sel_out by one cycle, so sample on the second cycle.
                    if (w_cnt_zero) begin
                        r_addr_q <= Address_in;
                        r_ctrl_q <= Control_in;
                        r_data_q <= Data_in;
                        r_state  <= c_DECODE;
                    end else begin
                        r_cnt <= r_cnt - 17'd1;
                    end
                end
                c_DECODE: begin
                    if (!r_ctrl_q[1]) begin
                        r_state <= c_NEXT;
                    end else if (r_ctrl_q[3]) begin
                        r_lcd_rs     <= 1'b0;
                        r_lcd_db     <= {1'b1, r_addr_q[6:0]};
                        r_wait_ld    <= c_SHORT_LD;
                        r_addr_phase <= 1'b1;
                        r_cnt        <= c_SETUP_LD;
                        r_state      <= c_SETUP;
                    end else begin
                        r_lcd_rs     <= r_ctrl_q[0];
                        r_lcd_db     <= r_data_q;
                        r_wait_ld    <= w_data_wait;
                        r_addr_phase <= 1'b0;
                        r_cnt        <= c_SETUP_LD;
                        r_state      <= c_SETUP;
                    end
                end
                c_SETUP: begin
                    if (w_cnt_zero) begin
                        r_lcd_e <= 1'b1;
                        r_cnt   <= c_PULSE_LD;
                        r_state <= c_PULSE;
                    end else begin
                        r_cnt <= r_cnt - 17'd1;
                    end
                end
                c_PULSE: begin
                    if (w_cnt_zero) begin
                        r_lcd_e <= 1'b0;
                        r_cnt   <= c_HOLD_LD;
                        r_state <= c_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 17'd1;
                    end
                end
                c_HOLD: begin
                    if (w_cnt_zero) begin
                        r_cnt   <= r_wait_ld;
                        r_state <= c_WAIT;
                    end else begin
                        r_cnt <= r_cnt - 17'd1;
                    end
                end
                c_WAIT: begin
                    if (w_cnt_zero) begin
                        if (r_addr_phase) begin
                            r_lcd_rs     <= r_ctrl_q[0];
                            r_lcd_db     <= r_data_q;
                            r_wait_ld    <= w_data_wait;
                            r_addr_phase <= 1'b0;
                            r_cnt        <= c_SETUP_LD;
                            r_state      <= c_SETUP;
                        end else begin
                            r_state <= c_NEXT;
                        end
                    end else begin
                        r_cnt <= r_cnt - 17'd1;
                    end
                end
                c_NEXT: begin
                    if (r_slot == 3'd7) begin
                        r_slot  <= 3'd0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_IDLE;
                    end else begin
                        r_slot  <= r_slot + 3'd1;
                        r_cnt   <= c_FETCH_LD;
                        r_state <= c_FETCH;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign sel_out = r_slot;
    assign status  = {3'b000, r_slot, r_done, r_busy};
    assign busy    = r_busy;
    assign lcd_rs  = r_lcd_rs;
    assign lcd_rw  = 1'b0;
    assign lcd_e   = r_lcd_e;
    assign lcd_db  = r_lcd_db;

endmodule
`default_nettype wire
